// File: rtl/mem_load_arbiter.sv
// mem_load_arbiter: shares the unified instruction/data memory port between the
// RISC-V core (run mode) and the board-side loader (load mode). While loading,
// the core is held in reset. The loader sequences address and data phases, and
// the address auto-increments after each write. On exit, a timed release window
// runs before the core is let out of reset.
// Optional build macro: LOAD_CHECKSUM_EN adds ld_csum, a running sum of every
// word written in the current load session.
module mem_load_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_WORDS   = 64,
   parameter int RELEASE_CYC = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ext_sel,
   input  logic              ext_addr_vld,
   input  logic              ext_data_vld,
   input  logic              ext_we,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              ext_rvalid,
   output logic              ext_err,
   input  logic [ADDR_W-1:0] cpu_adr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rst_n,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       load_cnt,
   output logic              mode_load
`ifdef LOAD_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] ld_csum
`endif
);

   localparam int RC_W = (RELEASE_CYC > 2) ? $clog2(RELEASE_CYC) : 1;
   localparam logic [RC_W-1:0]   RC_LAST    = RC_W'(RELEASE_CYC - 1);
   localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(MEM_WORDS * 4);
   localparam logic [ADDR_W-1:0] WORD_MASK  = ~(ADDR_W'(3));

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_LOAD = 2'd1,
      ST_REL  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [RC_W-1:0]   r_rel_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_rdata;
   logic              r_rvalid;
   logic              r_err;
   logic [15:0]       r_load_cnt;

   logic              w_enter_load;
   logic              w_mode_chg;
   logic              w_active;
   logic              w_in_range;
   logic              w_dphase;
   logic              w_wr;
   logic              w_rd;
   logic              w_err_set;

   // Next state, port ownership and core reset.
   always_comb begin
      w_state_nxt  = r_state;
      mode_load    = (r_state == ST_LOAD);
      cpu_rst_n    = 1'b0;
      w_enter_load = 1'b0;
      case (r_state)
         ST_RUN: begin
            cpu_rst_n = 1'b1;
            if (ext_sel) begin
               w_state_nxt  = ST_LOAD;
               cpu_rst_n    = 1'b0;
               w_enter_load = 1'b1;
            end
         end
         ST_LOAD: begin
            if (!ext_sel) w_state_nxt = ST_REL;
         end
         ST_REL: begin
            if (ext_sel)                     w_state_nxt = ST_LOAD;
            else if (r_rel_cnt == RC_LAST)   w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_LOAD;
      endcase
      w_mode_chg = ((w_state_nxt == ST_LOAD) != (r_state == ST_LOAD));
   end

   // Loader access decode. Accesses are only honoured while the loader keeps
   // ext_sel high, so a strobe in the exit cycle cannot write during handover.
   always_comb begin
      w_active   = (r_state == ST_LOAD) && ext_sel;
      w_in_range = ({1'b0, r_addr} < ADDR_LIMIT);
      w_dphase   = w_active && ext_data_vld && !ext_addr_vld;
      w_wr       = w_dphase && ext_we && w_in_range;
      w_rd       = w_dphase && !ext_we && w_in_range;
      w_err_set  = w_active && ext_data_vld && (ext_addr_vld || !w_in_range);
   end

   // Memory port multiplexer; no write is allowed in a cycle where ownership flips.
   always_comb begin
      if (mode_load) begin
         mem_adr   = r_addr;
         mem_wdata = ext_wdata;
         mem_we    = w_wr && !w_mode_chg;
      end else begin
         mem_adr   = cpu_adr;
         mem_wdata = cpu_wdata;
         mem_we    = cpu_we && !w_mode_chg;
      end
   end

   assign cpu_rdata  = mem_rdata;
   assign ext_rdata  = r_rdata;
   assign ext_rvalid = r_rvalid;
   assign ext_err    = r_err;
   assign load_cnt   = r_load_cnt;

   // State register and release window counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_LOAD;
         r_rel_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_REL) r_rel_cnt <= r_rel_cnt + 1'b1;
         else                   r_rel_cnt <= '0;
      end
   end

   // Loader datapath: address pointer, read-back, error flag and word counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr     <= '0;
         r_rdata    <= '0;
         r_rvalid   <= 1'b0;
         r_err      <= 1'b0;
         r_load_cnt <= '0;
      end else begin
         r_rvalid <= w_rd;
         if (w_active && ext_addr_vld)
            r_addr <= ADDR_W'(ext_wdata) & WORD_MASK;
         else if (w_wr)
            r_addr <= r_addr + ADDR_W'(4);
         if (w_rd) r_rdata <= mem_rdata;
         if (w_enter_load || ((r_state == ST_REL) && ext_sel))
            r_err <= 1'b0;
         else if (w_err_set)
            r_err <= 1'b1;
         if (w_enter_load)
            r_load_cnt <= '0;
         else if (w_wr && (r_load_cnt != 16'hFFFF))
            r_load_cnt <= r_load_cnt + 16'd1;
      end
   end

`ifdef LOAD_CHECKSUM_EN
   logic [DATA_W-1:0] r_csum;
   assign ld_csum = r_csum;

   // Session checksum of successfully written words.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)            r_csum <= '0;
      else if (w_enter_load) r_csum <= '0;
      else if (w_wr)         r_csum <= r_csum + ext_wdata;
   end
`endif

endmodule

// File: tb/tb_mem_load_arbiter.sv
// tb_mem_load_arbiter: directed stimulus with a write/read scoreboard for
// mem_load_arbiter. Optional build macro: LOAD_CHECKSUM_EN.
module tb_mem_load_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        ext_sel, ext_addr_vld, ext_data_vld, ext_we;
   logic [31:0] ext_wdata, ext_rdata;
   logic        ext_rvalid, ext_err;
   logic [31:0] cpu_adr, cpu_wdata, cpu_rdata;
   logic        cpu_we, cpu_rst_n;
   logic [31:0] mem_adr, mem_wdata, mem_rdata;
   logic        mem_we;
   logic [15:0] load_cnt;
   logic        mode_load;
`ifdef LOAD_CHECKSUM_EN
   logic [31:0] ld_csum;
`endif

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   typedef struct { logic [31:0] a; logic [31:0] d; int c; } wr_t;
   typedef struct { logic [31:0] d; int c; } rd_t;
   wr_t wq[$];
   rd_t rq[$];

   logic [31:0] mem [0:63];

   mem_load_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_WORDS(64), .RELEASE_CYC(4)
   ) dut (
      .clk(clk), .reset(reset), .ext_sel(ext_sel), .ext_addr_vld(ext_addr_vld),
      .ext_data_vld(ext_data_vld), .ext_we(ext_we), .ext_wdata(ext_wdata),
      .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid), .ext_err(ext_err),
      .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
      .cpu_rdata(cpu_rdata), .cpu_rst_n(cpu_rst_n), .mem_adr(mem_adr),
      .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .load_cnt(load_cnt), .mode_load(mode_load)
`ifdef LOAD_CHECKSUM_EN
      , .ld_csum(ld_csum)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: preset pattern during reset, otherwise a simple write port.
   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 + 32'(i);
      end else if (mem_we) begin
         mem[mem_adr[7:2]] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_adr[7:2]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Monitor: every memory write and every read-back pulse must match the queue.
   always @(negedge clk) begin
      if (reset === 1'b1 && mem_we === 1'b1) begin
         if (wq.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: adr %h data %h, no write expected", mem_adr, mem_wdata);
         end else begin
            wr_t e;
            e = wq.pop_front();
            chk("wr_adr", mem_adr, e.a);
            chk("wr_data", mem_wdata, e.d);
            chk("wr_cycle", 32'(cyc), 32'(e.c));
         end
      end
      if (reset === 1'b1 && ext_rvalid === 1'b1) begin
         if (rq.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_rvalid: rdata %h, no read expected", ext_rdata);
         end else begin
            rd_t r;
            r = rq.pop_front();
            chk("rd_data", ext_rdata, r.d);
            chk("rd_cycle", 32'(cyc), 32'(r.c));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ext_addr(input logic [31:0] a);
      ext_addr_vld = 1'b1;
      ext_wdata    = a;
      step();
      ext_addr_vld = 1'b0;
   endtask

   task automatic ext_write(input logic [31:0] d, input logic expect_wr, input logic [31:0] exp_a);
      ext_data_vld = 1'b1;
      ext_we       = 1'b1;
      ext_wdata    = d;
      if (expect_wr) wq.push_back('{a: exp_a, d: d, c: cyc});
      step();
      ext_data_vld = 1'b0;
      ext_we       = 1'b0;
   endtask

   task automatic ext_read(input logic [31:0] exp_d);
      ext_data_vld = 1'b1;
      ext_we       = 1'b0;
      rq.push_back('{d: exp_d, c: cyc + 1});
      step();
      ext_data_vld = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; ext_sel = 1'b1; ext_addr_vld = 1'b0; ext_data_vld = 1'b0;
      ext_we = 1'b0; ext_wdata = '0; cpu_adr = '0; cpu_wdata = '0; cpu_we = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      chk("rst_mode_load", 32'(mode_load), 32'd1);
      chk("rst_ext_rdata", ext_rdata, 32'h0);
      chk("rst_ext_rvalid", 32'(ext_rvalid), 32'd0);
      chk("rst_ext_err", 32'(ext_err), 32'd0);
      chk("rst_load_cnt", 32'(load_cnt), 32'd0);
      step();
      reset = 1'b1;
      step();

      // Two sequential writes from address 0
      ext_addr(32'h0);
      ext_write(32'h0050_0113, 1'b1, 32'h0);
      ext_write(32'h00C0_0193, 1'b1, 32'h4);
      @(negedge clk);
      chk("load_cnt_2", 32'(load_cnt), 32'd2);
      chk("load_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      chk("mem0", mem[0], 32'h0050_0113);
      chk("mem1", mem[1], 32'h00C0_0193);
      step();

      // Read-back at 0x64 twice (pointer holds), then a write lands at 0x64
      ext_addr(32'h64);
      ext_read(32'hA500_0019);
      ext_read(32'hA500_0019);
      ext_write(32'h1111_1111, 1'b1, 32'h64);
      @(negedge clk);
      chk("load_cnt_3", 32'(load_cnt), 32'd3);
      step();

      // Handover: cpu_rst_n rises 5 edges after ext_sel falls
      ext_sel = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (i == 1) chk("rel_mode_load", 32'(mode_load), 32'd0);
         chk("rel_cpu_rst_n", 32'(cpu_rst_n), (i == 5) ? 32'd1 : 32'd0);
      end
      step();

      // Core owns memory; loader strobes are ignored
      cpu_adr = 32'h8; cpu_wdata = 32'hCAFE_F00D; cpu_we = 1'b1;
      wq.push_back('{a: 32'h8, d: 32'hCAFE_F00D, c: cyc});
      step();
      cpu_we = 1'b0; cpu_adr = 32'h4;
      ext_data_vld = 1'b1; ext_we = 1'b1; ext_wdata = 32'h99;
      @(negedge clk);
      chk("run_cpu_rdata", cpu_rdata, 32'h00C0_0193);
      step();
      ext_data_vld = 1'b0; ext_we = 1'b0;
      @(negedge clk);
      chk("run_load_cnt", 32'(load_cnt), 32'd3);
      chk("run_mem2", mem[2], 32'hCAFE_F00D);
      step();

      // Re-enter load mode: core write in the switching cycle is blocked
      ext_sel = 1'b1; cpu_we = 1'b1; cpu_adr = 32'hC; cpu_wdata = 32'h0BAD;
      @(negedge clk);
      chk("entry_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      chk("entry_mem_we", 32'(mem_we), 32'd0);
      step();
      cpu_we = 1'b0;
      @(negedge clk);
      chk("entry_mode_load", 32'(mode_load), 32'd1);
      chk("entry_load_cnt", 32'(load_cnt), 32'd0);
      step();

      // Last in-range word, then out-of-range write and read
      ext_addr(32'hFC);
      ext_write(32'h1234_5678, 1'b1, 32'hFC);
      ext_write(32'hDEAD_BEEF, 1'b0, 32'h0);
      @(negedge clk);
      chk("oob_err", 32'(ext_err), 32'd1);
      chk("oob_load_cnt", 32'(load_cnt), 32'd1);
      chk("oob_mem0", mem[0], 32'h0050_0113);
      step();
      ext_data_vld = 1'b1; ext_we = 1'b0;
      step();
      ext_data_vld = 1'b0;

      // Brief release, then back to load: error cleared, count retained
      ext_sel = 1'b0;
      step();
      step();
      ext_sel = 1'b1;
      step();
      @(negedge clk);
      chk("reentry_err", 32'(ext_err), 32'd0);
      chk("reentry_load_cnt", 32'(load_cnt), 32'd1);
      chk("reentry_mode_load", 32'(mode_load), 32'd1);
      step();

      // Address and data strobes together: address taken, data dropped
      ext_addr_vld = 1'b1; ext_data_vld = 1'b1; ext_we = 1'b1; ext_wdata = 32'h8;
      step();
      ext_addr_vld = 1'b0; ext_data_vld = 1'b0; ext_we = 1'b0;
      @(negedge clk);
      chk("coll_err", 32'(ext_err), 32'd1);
      chk("coll_load_cnt", 32'(load_cnt), 32'd1);
      step();
      ext_write(32'h77, 1'b1, 32'h8);
      @(negedge clk);
      chk("coll_next_cnt", 32'(load_cnt), 32'd2);
      step();

      // Full return to run, fresh session with checksum vectors
      ext_sel = 1'b0;
      repeat (6) step();
      ext_sel = 1'b1;
      step();
      ext_addr(32'h0);
      ext_write(32'h0000_0005, 1'b1, 32'h0);
      ext_write(32'h0000_000C, 1'b1, 32'h4);
      ext_write(32'hFFFF_FFFF, 1'b1, 32'h8);
      @(negedge clk);
      chk("sess_load_cnt", 32'(load_cnt), 32'd3);
`ifdef LOAD_CHECKSUM_EN
      chk("ld_csum", ld_csum, 32'h0000_0010);
`endif
      step();

      // Asynchronous reset mid-load
      ext_sel = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("areset_load_cnt", 32'(load_cnt), 32'd0);
      chk("areset_mode_load", 32'(mode_load), 32'd1);
      step();
      reset = 1'b1;
      repeat (3) step();

      chk("wq_drained", 32'(wq.size()), 32'd0);
      chk("rq_drained", 32'(rq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
